// File: rtl/mantissa_multiplier_seq_if.sv
// Operand/result bundle for the sequential mantissa multiplier.
// The master drives requests and operands; the slave returns status and results.
interface mantissa_multiplier_seq_if #(
    parameter int W = 23
);
    logic         start_in;
    logic [W-1:0] m_a_in;
    logic [W-1:0] m_b_in;
    logic         busy_out;
    logic         done_out;
    logic [W:0]   normal_m_out;
    logic         exp_inc_out;

    modport master (
        output start_in, m_a_in, m_b_in,
        input  busy_out, done_out, normal_m_out, exp_inc_out
    );

    modport slave (
        input  start_in, m_a_in, m_b_in,
        output busy_out, done_out, normal_m_out, exp_inc_out
    );
endinterface

// File: rtl/mantissa_multiplier_seq.sv
// Radix-2 shift-add multiplier for {1,A}*{1,B}, followed by a one-bit normalize step.
// Define MANT_MUL_STICKY_EN to fold all discarded product bits into the guard bit.
module mantissa_multiplier_seq #(
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    mantissa_multiplier_seq_if.slave    bus
);
    localparam int W  = MANTISSA_WIDTH;
    localparam int PW = 2 * W + 2;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(W);

    typedef enum logic [1:0] {IDLE, MULT, NORM} state_e;

    state_e          state_q, state_d;
    logic [W:0]      a_q, a_d;
    logic [W:0]      b_q, b_d;
    logic [PW-1:0]   p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W:0]      norm_q, norm_d;
    logic            exp_inc_q, exp_inc_d;
    logic            done_q, done_d;
    logic [W+1:0]    sum;
    logic            sticky_hi, sticky_lo;
    logic            unused_p_lsb;

    assign unused_p_lsb = p_q[0];

`ifdef MANT_MUL_STICKY_EN
    assign sticky_hi = |p_q[W-1:0];
    assign sticky_lo = |p_q[W-2:0];
`else
    assign sticky_hi = 1'b0;
    assign sticky_lo = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_in) state_d = MULT;
            MULT:    if (cnt_q == LAST_STEP) state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy_out     = (state_q != IDLE);
        bus.done_out     = done_q;
        bus.normal_m_out = norm_q;
        bus.exp_inc_out  = exp_inc_q;
    end

    // Each step halves the running sum and adds A at weight 2^(W+1) when the current B bit is set.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        norm_d    = norm_q;
        exp_inc_d = exp_inc_q;
        done_d    = 1'b0;
        sum       = {1'b0, p_q[PW-1:W+1]} + (b_q[0] ? {1'b0, a_q} : '0);
        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    a_d   = {1'b1, bus.m_a_in};
                    b_d   = {1'b1, bus.m_b_in};
                    p_d   = '0;
                    cnt_d = '0;
                end
            end
            MULT: begin
                p_d   = {sum, p_q[W:1]};
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
            end
            NORM: begin
                if (p_q[PW-1]) begin
                    norm_d    = {p_q[2*W:W+1], p_q[W] | sticky_hi};
                    exp_inc_d = 1'b1;
                end else begin
                    norm_d    = {p_q[2*W-1:W], p_q[W-1] | sticky_lo};
                    exp_inc_d = 1'b0;
                end
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            norm_q    <= '0;
            exp_inc_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            norm_q    <= norm_d;
            exp_inc_q <= exp_inc_d;
            done_q    <= done_d;
        end
    end
endmodule
